mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported, fixed-latency unified memory between the pipeline's fetch port (IF) and data port (DM).
//  Sits between arm core and memory; replaces separate imem/dmem. Serialises accesses, returns read data, and
//  exposes per-port stall outputs that feed the hazard unit (StallF / M-stage stall).
// PARAMETERS
//  ADDR_W      32  address width, byte address
//  DATA_W      32  data word width
//  MEM_LAT     2   cycles from mem_en to valid mem_rdata / write commit (>=1)
//  STARVE_MAX  3   consecutive DM grants while IF waits before IF is forced to win
// PORTS
//  clk        in   1       system clock, rising edge
//  rst        in   1       asynchronous, active-high reset
//  if_req     in   1       fetch request, level; held with if_addr stable until if_done
//  if_addr    in   ADDR_W  fetch address (PCF)
//  if_rdata   out  DATA_W  fetched instruction; valid on if_done, held until next if_done
//  if_done    out  1       one-cycle pulse: fetch complete
//  dm_req     in   1       data request, level; held with addr/we/wdata stable until dm_done
//  dm_we      in   1       1 = store, 0 = load
//  dm_addr    in   ADDR_W  data address (ALUResult)
//  dm_wdata   in   DATA_W  store data
//  dm_rdata   out  DATA_W  load data; valid on dm_done, held until next DM load done
//  dm_done    out  1       one-cycle pulse: data access complete
//  stall_if   out  1       if_req & ~if_done
//  stall_dm   out  1       dm_req & ~dm_done
//  mem_en     out  1       one-cycle issue strobe to memory
//  mem_we     out  1       write enable, qualified by mem_en
//  mem_addr   out  ADDR_W  memory address, valid with mem_en
//  mem_wdata  out  DATA_W  memory write data, valid with mem_en
//  mem_rdata  in   DATA_W  memory read data, valid MEM_LAT cycles after mem_en
//  perf_if_cnt   out 32    fetch grants (ARB_PERF_EN)
//  perf_dm_cnt   out 32    data grants (ARB_PERF_EN)
//  perf_conf_cnt out 32    IDLE cycles with both requests pending (ARB_PERF_EN)
// BEHAVIOUR
//  Reset (async): state IDLE, lat_cnt 0, starve_cnt 0, if_rdata/dm_rdata 0, done/stall/mem_* outputs 0, perf counters 0.
//   A memory response in flight at reset is discarded.
//  FSM states: IDLE, BUSY_IF, BUSY_DM.
//  IDLE: no request -> stay, mem_en=0. Request pending -> issue this cycle (mem_en=1, mem_* from winner, combinational),
//   load lat_cnt=MEM_LAT-1, go BUSY_IF/BUSY_DM next edge.
//  Arbitration, both pending: DM wins unless starve_cnt==STARVE_MAX, then IF wins.
//  starve_cnt: +1 on DM grant while if_req=1 (saturates at STARVE_MAX); cleared on IF grant or when if_req=0 in IDLE.
//  BUSY_x: lat_cnt decrements each cycle; when lat_cnt==0: x_done=1, x_rdata = mem_rdata this cycle and registered
//   for hold (stores leave dm_rdata unchanged), next state IDLE.
//  Latency: issue at cycle T -> done at T+MEM_LAT; earliest next issue T+MEM_LAT+1; peak 1 access / (MEM_LAT+1) cycles.
//  Requester sees done and updates/drops req on the following cycle; arbiter never reissues from a done cycle.
//  req dropped while BUSY: access completes, done still pulses (requester ignores). mem_we only meaningful with mem_en.
//  lat_cnt width $clog2(MEM_LAT)+1; MEM_LAT=1 -> done the cycle after issue.
// CONFIGURATION
//  ARB_PERF_EN defined: perf_* are 32-bit wrapping counters, +1 per IF grant, DM grant, conflict cycle.
//  ARB_PERF_EN undefined: perf_* ports remain, tied to 0; no counter flops inferred.
// STRUCTURE
//  Package mem_arb_pkg: typedef enum logic[1:0] arb_state_t {IDLE,BUSY_IF,BUSY_DM}; typedef enum logic {SRC_IF,SRC_DM}
//   arb_src_t; localparam default MEM_LAT/STARVE_MAX.
//  Sub-module mem_arb_lat_cnt: loadable down-counter (load, load_val, cnt, zero flag), instanced once.
//  Top: FSM, winner select, starve counter, rdata hold regs, perf counters.
// TESTING
//  1 IF only, MEM_LAT=2: if_req=1 @0, addr 0x10, mem returns 0xE3A01005 -> mem_en @0, if_done+if_rdata=0xE3A01005 @2.
//  2 Simultaneous @0: if addr 0x20, dm load 0x100 -> DM issued @0, dm_done @2; IF issued @3, if_done @5.
//  3 Starvation, STARVE_MAX=3: dm_req and if_req held high continuously -> grants DM,DM,DM,IF,DM...; starve_cnt clears.
//  4 Store: dm_we=1 addr 0x80 wdata 0xDEADBEEF -> mem_en&mem_we one cycle, dm_done @T+2, dm_rdata unchanged.
//  5 Async rst asserted mid-BUSY_DM (lat_cnt=1) -> all outputs 0 immediately, no dm_done; after release IF issues first.
//  6 ARB_PERF_EN on, 4 IF + 2 DM grants, 1 conflict cycle -> perf_if_cnt=4, perf_dm_cnt=2, perf_conf_cnt=1; off -> all 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and default parameters for the unified-memory port arbiter.
package mem_arb_pkg;

   localparam int unsigned MEM_LAT_DEF    = 2;
   localparam int unsigned STARVE_MAX_DEF = 3;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY_IF = 2'd1,
      BUSY_DM = 2'd2
   } arb_state_t;

   typedef enum logic {
      SRC_IF = 1'b0,
      SRC_DM = 1'b1
   } arb_src_t;

endpackage

// File: rtl/mem_arb_lat_cnt.sv
// Loadable down-counter that times the fixed memory latency of one access.
// The counter stops at zero; zero_o flags the completion cycle.
module mem_arb_lat_cnt #(
   parameter int unsigned W = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         dec_i,
   output logic [W-1:0] cnt_o,
   output logic         zero_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Next count: load wins over decrement, hold at zero.
   always_comb begin
      // NOTE: default first so every path assigns cnt_d and no latch is inferred.
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: non-blocking assignments keep all flops updating from pre-edge values.
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o  = cnt_q;
   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-ported fixed-latency memory between fetch (IF) and data (DM)
// ports. DM has priority unless IF has waited through STARVE_MAX DM grants.
// Optional performance counters are built when ARB_PERF_EN is defined.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned MEM_LAT    = MEM_LAT_DEF,
   parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic [DATA_W-1:0] if_rdata_o,
   output logic              if_done_o,
   input  logic              dm_req_i,
   input  logic              dm_we_i,
   input  logic [ADDR_W-1:0] dm_addr_i,
   input  logic [DATA_W-1:0] dm_wdata_i,
   output logic [DATA_W-1:0] dm_rdata_o,
   output logic              dm_done_o,
   output logic              stall_if_o,
   output logic              stall_dm_o,
   output logic              mem_en_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic [31:0]       perf_if_cnt_o,
   output logic [31:0]       perf_dm_cnt_o,
   output logic [31:0]       perf_conf_cnt_o
);

   localparam int unsigned CNT_W = $clog2(MEM_LAT) + 1;
   localparam int unsigned SC_W  = $clog2(STARVE_MAX + 1);

   arb_state_t        state_q, state_d;
   arb_src_t          win_src;
   logic [SC_W-1:0]   starve_q, starve_d;
   logic [DATA_W-1:0] if_rdata_q, dm_rdata_q;
   logic              dm_we_q;
   logic [CNT_W-1:0]  lat_cnt;
   logic              lat_zero;
   logic              any_req;
   logic              starved;

   assign any_req = if_req_i | dm_req_i;
   assign starved = if_req_i && (starve_q == SC_W'(STARVE_MAX));

   mem_arb_lat_cnt #(.W(CNT_W)) u_lat_cnt (
      .clk        (clk),
      .rst        (rst),
      .load_i     (mem_en_o),
      .load_val_i (CNT_W'(MEM_LAT - 1)),
      .dec_i      ((state_q != IDLE) && (lat_cnt != '0)),
      .cnt_o      (lat_cnt),
      .zero_o     (lat_zero)
   );

   // Winner select: DM first unless IF has hit the starvation limit.
   always_comb begin
      win_src = SRC_IF;
      if (dm_req_i && !starved) begin
         win_src = SRC_DM;
      end
   end

   // FSM next state.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (any_req) state_d = (win_src == SRC_DM) ? BUSY_DM : BUSY_IF;
         BUSY_IF,
         BUSY_DM: if (lat_zero) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // FSM outputs: issue strobe with winner's fields in IDLE, done pulse when latency expires.
   always_comb begin
      mem_en_o    = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      if_done_o   = 1'b0;
      dm_done_o   = 1'b0;
      // NOTE: outputs are forced low while rst is high, since the request inputs
      // reach them combinationally and the state register alone cannot silence them.
      if (!rst) begin
         case (state_q)
            IDLE: begin
               if (any_req) begin
                  mem_en_o = 1'b1;
                  if (win_src == SRC_DM) begin
                     mem_we_o    = dm_we_i;
                     mem_addr_o  = dm_addr_i;
                     mem_wdata_o = dm_wdata_i;
                  end else begin
                     mem_addr_o  = if_addr_i;
                  end
               end
            end
            BUSY_IF: if_done_o = lat_zero;
            BUSY_DM: dm_done_o = lat_zero;
            default: ;
         endcase
      end
   end

   // Starvation count: DM grants while IF waits, cleared by an IF grant or an idle IF.
   always_comb begin
      starve_d = starve_q;
      if (state_q == IDLE) begin
         if (!if_req_i || (any_req && win_src == SRC_IF)) begin
            starve_d = '0;
         end else if (any_req && !starved) begin
            starve_d = starve_q + SC_W'(1);
         end
      end
   end

   // Starve counter, issued-store flag and read-data hold registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_q   <= '0;
         dm_we_q    <= 1'b0;
         if_rdata_q <= '0;
         dm_rdata_q <= '0;
      end else begin
         starve_q <= starve_d;
         if (mem_en_o && win_src == SRC_DM) dm_we_q    <= dm_we_i;
         if (if_done_o)                     if_rdata_q <= mem_rdata_i;
         if (dm_done_o && !dm_we_q)         dm_rdata_q <= mem_rdata_i;
      end
   end

   // Read data: live memory data in the done cycle, held value otherwise.
   always_comb begin
      if_rdata_o = if_done_o ? mem_rdata_i : if_rdata_q;
      dm_rdata_o = (dm_done_o && !dm_we_q) ? mem_rdata_i : dm_rdata_q;
   end

   assign stall_if_o = !rst && if_req_i && !if_done_o;
   assign stall_dm_o = !rst && dm_req_i && !dm_done_o;

`ifdef ARB_PERF_EN
   logic [31:0] perf_if_q, perf_dm_q, perf_conf_q;

   // Wrapping grant and conflict counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_if_q   <= '0;
         perf_dm_q   <= '0;
         perf_conf_q <= '0;
      end else begin
         if (mem_en_o && win_src == SRC_IF) perf_if_q <= perf_if_q + 32'd1;
         if (mem_en_o && win_src == SRC_DM) perf_dm_q <= perf_dm_q + 32'd1;
         if (state_q == IDLE && if_req_i && dm_req_i) perf_conf_q <= perf_conf_q + 32'd1;
      end
   end

   assign perf_if_cnt_o   = perf_if_q;
   assign perf_dm_cnt_o   = perf_dm_q;
   assign perf_conf_cnt_o = perf_conf_q;
`else
   assign perf_if_cnt_o   = '0;
   assign perf_dm_cnt_o   = '0;
   assign perf_conf_cnt_o = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter (MEM_LAT=2, STARVE_MAX=3): directed
// scenarios followed by random two-port traffic against a transaction-level model.
module tb_mem_port_arbiter;

   localparam int LAT  = 2;
   localparam int SMAX = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, dm_req, dm_we;
   logic [31:0] if_addr, dm_addr, dm_wdata;
   logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
   logic        if_done, dm_done, stall_if, stall_dm, mem_en, mem_we;
   logic [31:0] perf_if, perf_dm, perf_conf;

   int tests_run    = 0;
   int tests_failed = 0;
   int cyc          = 0;

   logic [31:0] exp_if_hold, exp_dm_hold;
   logic [31:0] ref_mem [int];

   always #5 clk = ~clk;

   mem_port_arbiter dut (
      .clk             (clk),
      .rst             (rst),
      .if_req_i        (if_req),
      .if_addr_i       (if_addr),
      .if_rdata_o      (if_rdata),
      .if_done_o       (if_done),
      .dm_req_i        (dm_req),
      .dm_we_i         (dm_we),
      .dm_addr_i       (dm_addr),
      .dm_wdata_i      (dm_wdata),
      .dm_rdata_o      (dm_rdata),
      .dm_done_o       (dm_done),
      .stall_if_o      (stall_if),
      .stall_dm_o      (stall_dm),
      .mem_en_o        (mem_en),
      .mem_we_o        (mem_we),
      .mem_addr_o      (mem_addr),
      .mem_wdata_o     (mem_wdata),
      .mem_rdata_i     (mem_rdata),
      .perf_if_cnt_o   (perf_if),
      .perf_dm_cnt_o   (perf_dm),
      .perf_conf_cnt_o (perf_conf)
   );

   // Power-on contents of the memory; word 4 (byte 0x10) holds a known instruction.
   function automatic logic [31:0] init_val(input int idx);
      return (idx == 4) ? 32'hE3A01005 : ((32'(idx) * 32'h9E3779B9) ^ 32'h5A5A_0F0F);
   endfunction

   // Memory device: writes at issue, read data appears LAT cycles after issue.
   logic [31:0] mem_arr [int];
   logic [31:0] rd_pipe [LAT];
   assign mem_rdata = rd_pipe[LAT-1];

   always @(posedge clk) begin
      int idx;
      idx = int'(mem_addr[9:2]);
      if (mem_en && mem_we) mem_arr[idx] = mem_wdata;
      rd_pipe[1] <= rd_pipe[0];
      rd_pipe[0] <= (mem_en && !mem_we) ? (mem_arr.exists(idx) ? mem_arr[idx] : init_val(idx))
                                        : 32'hBAD0_BAD0;
   end

   // Reference view of memory contents.
   function automatic logic [31:0] ref_rd(input logic [31:0] addr);
      int idx;
      idx = int'(addr[9:2]);
      return ref_mem.exists(idx) ? ref_mem[idx] : init_val(idx);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests_run++;
      assert (obs === expv) else begin
         tests_failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic idle_inputs();
      if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
      if_addr = '0; dm_addr = '0; dm_wdata = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      exp_if_hold = '0;
      exp_dm_hold = '0;
   endtask

   // Single fetch with the DM port idle; checks issue, latency, data and hold.
   task automatic if_access(input logic [31:0] addr, input string tag);
      logic [31:0] e;
      step();
      if_req = 1'b1; if_addr = addr;
      settle();
      check({tag, "_en"},    32'(mem_en),   32'd1);
      check({tag, "_addr"},  mem_addr,      addr);
      check({tag, "_stall"}, 32'(stall_if), 32'd1);
      e = ref_rd(addr);
      step(); settle();
      check({tag, "_busy"},  32'(if_done),  32'd0);
      step(); settle();
      check({tag, "_done"},  32'(if_done),  32'd1);
      check({tag, "_rdata"}, if_rdata,      e);
      check({tag, "_nostall"}, 32'(stall_if), 32'd0);
      exp_if_hold = e;
      step();
      if_req = 1'b0;
      settle();
      check({tag, "_hold"},  if_rdata,      e);
   endtask

   // Single data access with the IF port idle.
   task automatic dm_access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                            input string tag);
      logic [31:0] e;
      step();
      dm_req = 1'b1; dm_we = we; dm_addr = addr; dm_wdata = wd;
      settle();
      check({tag, "_en"},   32'(mem_en), 32'd1);
      check({tag, "_we"},   32'(mem_we), 32'(we));
      check({tag, "_addr"}, mem_addr,    addr);
      if (we) begin
         check({tag, "_wdata"}, mem_wdata, wd);
         ref_mem[int'(addr[9:2])] = wd;
         e = exp_dm_hold;
      end else begin
         e = ref_rd(addr);
      end
      step(); settle();
      check({tag, "_one_strobe"}, 32'(mem_en), 32'd0);
      step(); settle();
      check({tag, "_done"},  32'(dm_done), 32'd1);
      check({tag, "_rdata"}, dm_rdata,     e);
      exp_dm_hold = e;
      step();
      dm_req = 1'b0;
      settle();
      check({tag, "_after"}, 32'(dm_done), 32'd0);
   endtask

   // Watchdog so the run always terminates.
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      // ---------------- reset state, requests already asserted ----------------
      rst = 1'b1;
      if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b1;
      if_addr = 32'h40; dm_addr = 32'h44; dm_wdata = 32'h1;
      #3;
      check("rst_mem_en",   32'(mem_en),   32'd0);
      check("rst_mem_we",   32'(mem_we),   32'd0);
      check("rst_mem_addr", mem_addr,      32'd0);
      check("rst_stall_if", 32'(stall_if), 32'd0);
      check("rst_stall_dm", 32'(stall_dm), 32'd0);
      check("rst_if_done",  32'(if_done),  32'd0);
      check("rst_dm_done",  32'(dm_done),  32'd0);
      check("rst_if_rdata", if_rdata,      32'd0);
      check("rst_dm_rdata", dm_rdata,      32'd0);
      check("rst_perf_if",  perf_if,       32'd0);
      do_reset();

      // ---------------- 1: IF only ----------------
      if_access(32'h10, "t1");
      check("t1_instr", if_rdata, 32'hE3A01005);

      // ---------------- 2: simultaneous, DM first ----------------
      step();
      if_req = 1'b1; if_addr = 32'h20;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100;
      settle();
      check("t2_dm_issue", mem_addr, 32'h100);
      check("t2_en",       32'(mem_en), 32'd1);
      step(); step(); settle();
      check("t2_dm_done",  32'(dm_done),  32'd1);
      check("t2_dm_rdata", dm_rdata,      ref_rd(32'h100));
      check("t2_if_wait",  32'(stall_if), 32'd1);
      exp_dm_hold = ref_rd(32'h100);
      step();
      dm_req = 1'b0;
      settle();
      check("t2_if_issue", mem_addr,      32'h20);
      check("t2_if_en",    32'(mem_en),   32'd1);
      check("t2_dm_stall", 32'(stall_dm), 32'd0);
      step(); step(); settle();
      check("t2_if_done",  32'(if_done),  32'd1);
      check("t2_if_rdata", if_rdata,      ref_rd(32'h20));
      exp_if_hold = ref_rd(32'h20);
      step();
      if_req = 1'b0;

      // ---------------- 4: store, then load back ----------------
      dm_access(1'b1, 32'h80, 32'hDEADBEEF, "t4_st");
      check("t4_commit", mem_arr[32], 32'hDEADBEEF);
      dm_access(1'b0, 32'h80, 32'h0, "t4_ld");

      // ---------------- 3: starvation, both held high ----------------
      step();
      if_req = 1'b1; if_addr = 32'h30;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h34;
      for (int k = 0; k < 5; k++) begin
         settle();
         check($sformatf("t3_grant%0d_en", k),   32'(mem_en), 32'd1);
         check($sformatf("t3_grant%0d_addr", k), mem_addr, (k == 3) ? 32'h30 : 32'h34);
         step(); step(); settle();
         if (k == 3) begin
            check("t3_if_done",  32'(if_done), 32'd1);
            check("t3_if_rdata", if_rdata,     ref_rd(32'h30));
         end else begin
            check($sformatf("t3_dm_done%0d", k), 32'(dm_done), 32'd1);
            check($sformatf("t3_dm_rdata%0d", k), dm_rdata,    ref_rd(32'h34));
         end
         step();
      end
      idle_inputs();
      settle();
      check("t3_quiet", 32'(mem_en), 32'd0);

      // ---------------- 5: async reset during BUSY_DM ----------------
      step();
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100;
      settle();
      check("t5_issue", 32'(mem_en), 32'd1);
      step();
      rst = 1'b1; if_req = 1'b1; if_addr = 32'h50;
      settle();
      check("t5_rst_en",       32'(mem_en),   32'd0);
      check("t5_rst_dm_done",  32'(dm_done),  32'd0);
      check("t5_rst_stall_dm", 32'(stall_dm), 32'd0);
      check("t5_rst_stall_if", 32'(stall_if), 32'd0);
      check("t5_rst_dm_rdata", dm_rdata,      32'd0);
      check("t5_rst_if_rdata", if_rdata,      32'd0);
      step(); settle();
      check("t5_no_late_done", 32'(dm_done), 32'd0);
      step();
      rst = 1'b0; dm_req = 1'b0;
      exp_if_hold = '0; exp_dm_hold = '0;
      settle();
      check("t5_if_first_en",   32'(mem_en), 32'd1);
      check("t5_if_first_addr", mem_addr,    32'h50);
      step(); step(); settle();
      check("t5_if_done",  32'(if_done), 32'd1);
      check("t5_if_rdata", if_rdata,     ref_rd(32'h50));
      step();
      if_req = 1'b0;

      // ---------------- 6: performance counters ----------------
      do_reset();
      if_access(32'h60, "t6_if0");
      if_access(32'h64, "t6_if1");
      if_access(32'h68, "t6_if2");
      step();
      if_req = 1'b1; if_addr = 32'h6C;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h70;
      settle();
      check("t6_conf_winner", mem_addr, 32'h70);
      step(); step(); settle();
      check("t6_conf_dm_done", 32'(dm_done), 32'd1);
      step();
      dm_req = 1'b0;
      settle();
      check("t6_if_after", mem_addr, 32'h6C);
      step(); step(); settle();
      check("t6_if_done", 32'(if_done), 32'd1);
      step();
      if_req = 1'b0;
      dm_access(1'b0, 32'h74, 32'h0, "t6_dm1");
`ifdef ARB_PERF_EN
      check("t6_perf_if",   perf_if,   32'd4);
      check("t6_perf_dm",   perf_dm,   32'd2);
      check("t6_perf_conf", perf_conf, 32'd1);
`else
      check("t6_perf_if",   perf_if,   32'd0);
      check("t6_perf_dm",   perf_dm,   32'd0);
      check("t6_perf_conf", perf_conf, 32'd0);
`endif

      // ---------------- random two-port traffic vs transaction model ----------------
      begin
         int          free_at, starve, if_done_at, dm_done_at;
         int          m_if_gr, m_dm_gr, m_conf;
         bit          if_pend, dm_pend, if_iss, dm_iss, e_if_done, e_dm_done, e_en, e_we;
         logic [31:0] e_addr, if_data, dm_data;

         do_reset();
         free_at = cyc; starve = 0; if_done_at = -1; dm_done_at = -1;
         m_if_gr = 0; m_dm_gr = 0; m_conf = 0;
         if_pend = 0; dm_pend = 0; if_iss = 0; dm_iss = 0;
         if_data = '0; dm_data = '0;

         for (int n = 0; n < 400; n++) begin
            if (!if_pend && ($urandom_range(1, 0) == 1)) begin
               if_pend = 1; if_iss = 0;
               if_addr = {24'd0, 6'($urandom_range(63, 0)), 2'b00};
            end
            if (!dm_pend && ($urandom_range(1, 0) == 1)) begin
               dm_pend = 1; dm_iss = 0;
               dm_we    = 1'($urandom_range(1, 0));
               dm_addr  = {24'd0, 6'($urandom_range(63, 0)), 2'b00};
               dm_wdata = $urandom;
            end
            if_req = if_pend;
            dm_req = dm_pend;

            e_en = 0; e_we = 0; e_addr = '0;
            if (cyc >= free_at) begin
               if (!if_pend) starve = 0;
               if (if_pend && dm_pend) m_conf++;
               if (dm_pend && !(if_pend && starve == SMAX)) begin
                  e_en = 1; e_we = dm_we; e_addr = dm_addr;
                  dm_iss = 1; dm_done_at = cyc + LAT; free_at = cyc + LAT + 1;
                  if (if_pend && starve < SMAX) starve++;
                  if (dm_we) ref_mem[int'(dm_addr[9:2])] = dm_wdata;
                  else       dm_data = ref_rd(dm_addr);
                  m_dm_gr++;
               end else if (if_pend) begin
                  e_en = 1; e_addr = if_addr;
                  if_iss = 1; if_done_at = cyc + LAT; free_at = cyc + LAT + 1;
                  starve = 0;
                  if_data = ref_rd(if_addr);
                  m_if_gr++;
               end
            end
            e_if_done = if_pend && if_iss && (cyc == if_done_at);
            e_dm_done = dm_pend && dm_iss && (cyc == dm_done_at);
            if (e_if_done)           exp_if_hold = if_data;
            if (e_dm_done && !dm_we) exp_dm_hold = dm_data;

            settle();
            check("rnd_mem_en", 32'(mem_en), 32'(e_en));
            if (e_en) begin
               check("rnd_mem_addr", mem_addr,    e_addr);
               check("rnd_mem_we",   32'(mem_we), 32'(e_we));
            end
            check("rnd_if_done",  32'(if_done),  32'(e_if_done));
            check("rnd_dm_done",  32'(dm_done),  32'(e_dm_done));
            check("rnd_if_rdata", if_rdata,      exp_if_hold);
            check("rnd_dm_rdata", dm_rdata,      exp_dm_hold);
            check("rnd_stall_if", 32'(stall_if), 32'(if_pend && !e_if_done));
            check("rnd_stall_dm", 32'(stall_dm), 32'(dm_pend && !e_dm_done));

            if (e_if_done) if_pend = 0;
            if (e_dm_done) dm_pend = 0;
            step();
         end
         idle_inputs();
`ifdef ARB_PERF_EN
         check("rnd_perf_if",   perf_if,   32'(m_if_gr));
         check("rnd_perf_dm",   perf_dm,   32'(m_dm_gr));
         check("rnd_perf_conf", perf_conf, 32'(m_conf));
`else
         check("rnd_perf_if",   perf_if,   32'd0);
         check("rnd_perf_conf", perf_conf, 32'd0);
`endif
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
